// File: rtl/lut_regfile_ctrl.sv
// -----------------------------------------------------------------------------
// lut_regfile_ctrl
//   Lookup register block: d_in is staged in a hold register, committed to a
//   DEPTH-entry register file at address d_in[ADDR_W-1:0], and read back to
//   d_out. A clear_all command starts a multi-cycle sweep that zeroes one entry
//   per cycle while busy is high.
//
// Ports
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset
//   write_en    commit hold register to entry d_in[ADDR_W-1:0]
//   save_data   load d_in into hold register
//   show_reg    read entry d_in[ADDR_W-1:0] to d_out
//   clear_all   start the clear sweep
//   d_in        data (save) or address (write/show)
//   d_out       last shown value (registered)
//   show_valid  one-cycle strobe, d_out updated this cycle
//   busy        high while the clear sweep is in progress
//
// Configuration
//   LUT_ACCUM_EN  when defined, write_en adds hold into the addressed entry
//                 (modulo 2**DATA_W) instead of overwriting it.
// -----------------------------------------------------------------------------
module lut_regfile_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic              save_data,
    input  logic              show_reg,
    input  logic              clear_all,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    output logic              show_valid,
    output logic              busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [DATA_W-1:0]  hold_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [ADDR_W-1:0]  addr_c;
    logic               in_range_c;
    logic [DATA_W-1:0]  wdata_c;

    // Address decode and range check shared by write and show
    assign addr_c     = d_in[ADDR_W-1:0];
    assign in_range_c = ({1'b0, addr_c} < DEPTH_L);

    // Value committed by write_en
    always_comb begin
        wdata_c = hold_q;
`ifdef LUT_ACCUM_EN
        if (in_range_c) begin
            wdata_c = mem_q[addr_c] + hold_q;
        end
`endif
    end

    // Control FSM, register file, hold and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_q     <= '0;
            d_out      <= '0;
            show_valid <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            show_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Priority: clear_all > write_en > save_data > show_reg
                    if (clear_all) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                        busy    <= 1'b1;
                    end else if (write_en) begin
                        if (in_range_c) begin
                            mem_q[addr_c] <= wdata_c;
                        end
                    end else if (save_data) begin
                        hold_q <= d_in;
                    end else if (show_reg) begin
                        d_out      <= in_range_c ? mem_q[addr_c] : '0;
                        show_valid <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // One entry per cycle; commands are ignored here
                    mem_q[ptr_q] <= '0;
                    if (ptr_q == LAST_PTR) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + PTR_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_regfile_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lut_regfile_ctrl
//   Drives a DEPTH=16 and a DEPTH=12 instance with identical stimulus and
//   compares every cycle against a per-command array model of the register
//   file, followed by directed checks of the documented scenarios.
// -----------------------------------------------------------------------------
module tb_lut_regfile_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       write_en, save_data, show_reg, clear_all;
    logic [7:0] d_in;
    logic [7:0] dout_a, dout_b;
    logic       sv_a, sv_b, busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lut_regfile_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) u_a (
        .clk(clk), .rst(rst), .write_en(write_en), .save_data(save_data),
        .show_reg(show_reg), .clear_all(clear_all), .d_in(d_in),
        .d_out(dout_a), .show_valid(sv_a), .busy(busy_a)
    );

    lut_regfile_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) u_b (
        .clk(clk), .rst(rst), .write_en(write_en), .save_data(save_data),
        .show_reg(show_reg), .clear_all(clear_all), .d_in(d_in),
        .d_out(dout_b), .show_valid(sv_b), .busy(busy_b)
    );

    // Reference model: index 0 models DEPTH=16, index 1 models DEPTH=12
    logic [7:0] m_mem  [2][16];
    logic [7:0] m_hold [2];
    logic [7:0] m_dout [2];
    logic       m_valid[2];
    int         m_left [2];   // entries still to be zeroed by a sweep
    int         m_depth[2] = '{16, 12};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic clr, input logic we,
                              input logic sv, input logic sh, input logic [7:0] din);
        int a;
        a = int'(din[3:0]);
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            if (r) begin
                for (int j = 0; j < 16; j++) m_mem[k][j] = 8'h00;
                m_hold[k] = 8'h00;
                m_dout[k] = 8'h00;
                m_left[k] = 0;
            end else if (m_left[k] > 0) begin
                m_mem[k][m_depth[k] - m_left[k]] = 8'h00;
                m_left[k]--;
            end else if (clr) begin
                m_left[k] = m_depth[k];
            end else if (we) begin
                if (a < m_depth[k]) begin
`ifdef LUT_ACCUM_EN
                    m_mem[k][a] = 8'((int'(m_mem[k][a]) + int'(m_hold[k])) % 256);
`else
                    m_mem[k][a] = m_hold[k];
`endif
                end
            end else if (sv) begin
                m_hold[k] = din;
            end else if (sh) begin
                m_dout[k]  = (a < m_depth[k]) ? m_mem[k][a] : 8'h00;
                m_valid[k] = 1'b1;
            end
        end
    endtask

    // Apply one cycle of stimulus, advance the model and compare all outputs
    task automatic step(input logic r, input logic clr, input logic we,
                        input logic sv, input logic sh, input logic [7:0] din);
        rst = r; clear_all = clr; write_en = we; save_data = sv; show_reg = sh; d_in = din;
        @(posedge clk);
        model_edge(r, clr, we, sv, sh, din);
        #1;
        check("dout16",  dout_a, m_dout[0]);
        check("valid16", 8'(sv_a), 8'(m_valid[0]));
        check("busy16",  8'(busy_a), 8'(m_left[0] > 0));
        check("dout12",  dout_b, m_dout[1]);
        check("valid12", 8'(sv_b), 8'(m_valid[1]));
        check("busy12",  8'(busy_b), 8'(m_left[1] > 0));
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        int i;
        logic [7:0] r8;

        rst = 1'b0; clear_all = 1'b0; write_en = 1'b0;
        save_data = 1'b0; show_reg = 1'b0; d_in = 8'h00;
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = 8'h00; m_dout[k] = 8'h00; m_valid[k] = 1'b0; m_left[k] = 0;
            for (int j = 0; j < 16; j++) m_mem[k][j] = 8'h00;
        end

        // 1. reset, then show 0x03
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_dout", dout_a, 8'h00);
        check("rst_busy", 8'(busy_a), 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03);
        check("t1_valid", 8'(sv_a), 8'h01);
        check("t1_dout", dout_a, 8'h00);
        idle_step();
        check("t1_pulse", 8'(sv_a), 8'h00);

        // 2. two writes and two shows
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h15);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA3);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
        check("t2_show1", dout_a, 8'h15);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02);
        check("t2_show2", dout_a, 8'hA3);

        // 3. sweep with a write on sweep cycle 3
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h15);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        bc = (busy_a === 1'b1) ? 1 : 0;
        i  = 0;
        while (busy_a === 1'b1 && i < 40) begin
            i++;
            step(1'b0, 1'b0, (i == 3), 1'b0, 1'b0, 8'h01);
            if (busy_a === 1'b1) bc++;
        end
        check("t3_busy_len", 8'(bc), 8'd16);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
        check("t3_cleared", dout_a, 8'h00);

        // 4. write and show in the same cycle: show dropped
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h87);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05);
        check("t4_no_valid", 8'(sv_a), 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
        check("t4_show", dout_a, 8'h87);

        // 5. reset during sweep
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int s = 1; s < 5; s++) idle_step();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("t5_busy", 8'(busy_a), 8'h00);
        check("t5_dout", dout_a, 8'h00);
        for (int s = 0; s < 16; s++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(s));
            check("t5_entry", dout_a, 8'h00);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h07);  // hold must be zero
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07);
        check("t5_hold", dout_a, 8'h00);

        // 6. out-of-range write and show on the DEPTH=12 instance
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0E);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0E);
        check("t6_dout", dout_b, 8'h00);
        check("t6_valid", 8'(sv_b), 8'h01);
        check("t6_inrange", dout_a, 8'h5A);
        for (int s = 0; s < 12; s++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(s));
            check("t6_entry", dout_b, 8'h00);
        end

        // 7. two writes of 0xF0 to entry 4
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04);
`ifdef LUT_ACCUM_EN
        check("t7_accum", dout_a, 8'hE0);
`else
        check("t7_store", dout_a, 8'hF0);
`endif

        // Random commands against the model
        for (int n = 0; n < 600; n++) begin
            r8 = 8'($urandom);
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0),
                 r8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
